// File: rtl/demux_sched_pkg.sv
// Shared constants, state type and select decode for the round-robin demux scheduler.
// Combinational helpers only; no latency, no flow control.
package demux_sched_pkg;

    localparam int   NCH  = 4;
    localparam int   SELW = 2;
    localparam logic IDLE = 1'b0;
    localparam logic HOLD = 1'b1;

    typedef enum logic {
        ST_IDLE = IDLE,
        ST_HOLD = HOLD
    } state_t;

    function automatic logic [NCH-1:0] sel_onehot(input logic [SELW-1:0] s);
        logic [NCH-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Circular first-one finder: first enabled channel at or after ptr, wrapping 3->0.
// Purely combinational; none flags an all-zero mask.
module demux_rr_pick
    import demux_sched_pkg::*;
(
    input  logic [SELW-1:0] ptr,
    input  logic [NCH-1:0]  chan_en,
    output logic [SELW-1:0] nxt,
    output logic            none
);

    logic [SELW-1:0] idx;

    // Scan from the farthest offset back to ptr so the nearest enabled channel wins.
    always_comb begin
        nxt = ptr;
        idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = ptr + SELW'(k);
            if (chan_en[idx]) begin
                nxt = idx;
            end
        end
    end

    assign none = ~|chan_en;

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin 1-to-4 demux scheduler, one-word holding register, 1-cycle latency, full throughput.
// Word is held until the selected lane takes it; in_ready drops while stalled. DEMUX_SCHED_CNT_EN adds cnt_o.
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int W  = 8
`ifdef DEMUX_SCHED_CNT_EN
    ,
    parameter int CW = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            in_ready,
    input  logic [NCH-1:0]  chan_en,
    output logic [NCH-1:0]  out_valid,
    output logic [W-1:0]    out_data,
    input  logic [NCH-1:0]  out_ready,
`ifdef DEMUX_SCHED_CNT_EN
    output logic [NCH*CW-1:0] cnt_o,
`endif
    output logic [SELW-1:0] sel
);

    state_t          state_q, state_d;
    logic [W-1:0]    data_q,  data_d;
    logic [SELW-1:0] sel_q,   sel_d;
    logic [SELW-1:0] ptr_q,   ptr_d;

    logic [SELW-1:0] nxt;
    logic            none;
    logic            xfer;
    logic            accept;

    demux_rr_pick u_pick (
        .ptr     (ptr_q),
        .chan_en (chan_en),
        .nxt     (nxt),
        .none    (none)
    );

    assign xfer     = (state_q == ST_HOLD) && out_ready[sel_q];
    // rst_n gates in_ready so the producer never sees a handshake during reset.
    assign in_ready = rst_n && !none && ((state_q == ST_IDLE) || xfer);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    // ptr only moves on accept; a transfer or mask change leaves it alone.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = ST_HOLD;
            data_d  = in_data;
            sel_d   = nxt;
            ptr_d   = nxt + SELW'(1);
        end else if (xfer) begin
            state_d = ST_IDLE;
        end
    end

    assign out_valid = (state_q == ST_HOLD) ? sel_onehot(sel_q) : '0;
    assign out_data  = data_q;
    assign sel       = sel_q;

`ifdef DEMUX_SCHED_CNT_EN
    logic [CW-1:0] cnt_q [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[i] <= '0;
            end else if (xfer && (sel_q == SELW'(i))) begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
            end
        end
        assign cnt_o[i*CW +: CW] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
// Self-checking bench for demux_rr_sched: directed scenarios plus random traffic against a reference model.
module tb_demux_rr_sched;

    localparam int W = 8;
`ifdef DEMUX_SCHED_CNT_EN
    localparam int CW = 4;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [3:0]   chan_en;
    logic [3:0]   out_valid;
    logic [W-1:0] out_data;
    logic [3:0]   out_ready;
    logic [1:0]   sel;
`ifdef DEMUX_SCHED_CNT_EN
    logic [4*CW-1:0] cnt_o;
`endif

    always #5 clk = ~clk;

`ifdef DEMUX_SCHED_CNT_EN
    demux_rr_sched #(.W(W), .CW(CW)) dut (
`else
    demux_rr_sched #(.W(W)) dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .chan_en   (chan_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef DEMUX_SCHED_CNT_EN
        .cnt_o     (cnt_o),
`endif
        .sel       (sel)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: a one-word slot, the channel it is bound for, and the rotation pointer.
    bit           m_hold;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;
    int           m_cnt [4];

    function automatic int pick(input int ptr, input logic [3:0] en);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (ptr + k) % 4;
            if (en[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_hold = 0;
        m_data = '0;
        m_sel  = 0;
        m_ptr  = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge.
    task automatic step();
        int         c;
        bit         exp_rdy;
        bit         xf;
        logic [3:0] exp_ov;
        @(negedge clk);
        c       = pick(m_ptr, chan_en);
        exp_rdy = (c >= 0) && (!m_hold || out_ready[m_sel]);
        exp_ov  = m_hold ? 4'(1 << m_sel) : 4'b0000;
        nvec++;
        if (in_ready !== exp_rdy) begin
            nerr++;
            $display("FAIL step_in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
        end
        nvec++;
        if (out_valid !== exp_ov) begin
            nerr++;
            $display("FAIL step_out_valid t=%0t got %b want %b", $time, out_valid, exp_ov);
        end
        nvec++;
        if (sel !== 2'(m_sel)) begin
            nerr++;
            $display("FAIL step_sel t=%0t got %0d want %0d", $time, sel, m_sel);
        end
        nvec++;
        if (out_data !== m_data) begin
            nerr++;
            $display("FAIL step_out_data t=%0t got %h want %h", $time, out_data, m_data);
        end
`ifdef DEMUX_SCHED_CNT_EN
        begin
            logic [4*CW-1:0] exp_cnt;
            for (int i = 0; i < 4; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
            nvec++;
            if (cnt_o !== exp_cnt) begin
                nerr++;
                $display("FAIL step_cnt t=%0t got %h want %h", $time, cnt_o, exp_cnt);
            end
        end
`endif
        xf = m_hold && out_ready[m_sel];
        if (xf) m_cnt[m_sel] = m_cnt[m_sel] + 1;
        if (in_valid && exp_rdy) begin
            m_hold = 1;
            m_data = in_data;
            m_sel  = c;
            m_ptr  = (c + 1) % 4;
        end else if (xf) begin
            m_hold = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        chan_en   = 4'b1111;
        out_ready = 4'b1111;
        #2;
        nvec++;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        nvec++;
        if (out_valid !== 4'b0000) begin nerr++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
        nvec++;
        if (sel !== 2'd0) begin nerr++; $display("FAIL reset_sel got %0d want 0", sel); end
        nvec++;
        if (out_data !== 8'h00) begin nerr++; $display("FAIL reset_out_data got %h want 00", out_data); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_stream();
        chan_en   = 4'b1111;
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            step();
            nvec++;
            if (sel !== 2'(i % 4) || out_data !== 8'hA0 + 8'(i) || out_valid !== 4'(1 << (i % 4))) begin
                nerr++;
                $display("FAIL stream_word%0d got sel=%0d data=%h ov=%b want sel=%0d data=%h",
                         i, sel, out_data, out_valid, i % 4, 8'hA0 + 8'(i));
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mask();
        int         exp_ch [4] = '{0, 2, 0, 2};
        logic [3:0] seen_odd;
        seen_odd  = 4'b0000;
        chan_en   = 4'b0101;
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
            seen_odd |= out_valid & 4'b1010;
            nvec++;
            if (sel !== 2'(exp_ch[i])) begin
                nerr++;
                $display("FAIL mask_sel%0d got %0d want %0d", i, sel, exp_ch[i]);
            end
        end
        in_valid = 1'b0;
        step();
        seen_odd |= out_valid & 4'b1010;
        nvec++;
        if (seen_odd !== 4'b0000) begin nerr++; $display("FAIL mask_odd_lanes got %b want 0000", seen_odd); end
    endtask

    task automatic test_stall();
        chan_en   = 4'b0001;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        step();
        in_valid = 1'b0;
        step();
        chan_en   = 4'b1111;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'h5C;
        step();
        nvec++;
        if (sel !== 2'd1) begin nerr++; $display("FAIL stall_first_sel got %0d want 1", sel); end
        in_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            step();
            nvec++;
            if (out_valid !== 4'b0010 || out_data !== 8'h5C || in_ready !== 1'b0) begin
                nerr++;
                $display("FAIL stall_hold%0d got ov=%b data=%h rdy=%b want 0010 5c 0",
                         i, out_valid, out_data, in_ready);
            end
        end
        out_ready = 4'b0010;
        step();
        nvec++;
        if (sel !== 2'd2 || out_data !== 8'h77 || out_valid !== 4'b0100) begin
            nerr++;
            $display("FAIL stall_release got sel=%0d data=%h ov=%b want 2 77 0100", sel, out_data, out_valid);
        end
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        step();
    endtask

    task automatic test_none();
        chan_en   = 4'b0000;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        for (int i = 0; i < 6; i++) begin
            step();
            nvec++;
            if (in_ready !== 1'b0 || out_valid !== 4'b0000) begin
                nerr++;
                $display("FAIL none_stall%0d got rdy=%b ov=%b want 0 0000", i, in_ready, out_valid);
            end
        end
        chan_en = 4'b1000;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL none_unmask_rdy got %b want 1", in_ready); end
        step();
        nvec++;
        if (sel !== 2'd3 || out_valid !== 4'b1000 || out_data !== 8'h99) begin
            nerr++;
            $display("FAIL none_accept got sel=%0d ov=%b data=%h want 3 1000 99", sel, out_valid, out_data);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_hold();
        chan_en   = 4'b1111;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 4'b1111;
        rst_n     = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 4'b0000 || sel !== 2'd0 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL midhold_reset got ov=%b sel=%0d rdy=%b want 0000 0 0", out_valid, sel, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++;
            if (out_valid !== 4'b0000) begin
                nerr++;
                $display("FAIL midhold_after%0d got ov=%b want 0000", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            chan_en   = (($urandom % 8) == 0) ? 4'b0000 : 4'($urandom);
            out_ready = 4'($urandom);
            step();
        end
        in_valid  = 1'b0;
        chan_en   = 4'b1111;
        out_ready = 4'b1111;
        step();
    endtask

`ifdef DEMUX_SCHED_CNT_EN
    task automatic test_counters();
        do_reset();
        chan_en   = 4'b0001;
        out_ready = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        nvec++;
        if (cnt_o !== 16'h0001) begin nerr++; $display("FAIL cnt_wrap got %h want 0001", cnt_o); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_mask();
        test_stall();
        test_none();
        test_reset_mid_hold();
        test_random();
`ifdef DEMUX_SCHED_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
